// File: rtl/bus_addr_pkg.sv
// Shared types and helpers for the bus address sequencer.
// Holds the FSM state enum, the burst-type codes and a power-of-two check.
package bus_addr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic BURST_INCR = 1'b0;
    localparam logic BURST_WRAP = 1'b1;

    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/bus_wrap_mask.sv
// Wrap-window mask for a burst: (len+1)*STEP-1 for a legal wrapping burst,
// all ones otherwise. Ports: len, wrap in; mask out (combinational).
module bus_wrap_mask
    import bus_addr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LEN_W = 4,
    parameter int STEP  = 8
) (
    input  logic [LEN_W-1:0] len,
    input  logic             wrap,
    output logic [WIDTH-1:0] mask
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [31:0]      beats;
    logic [WIDTH-1:0] span;

    assign beats = 32'(len) + 32'd1;
    assign span  = WIDTH'(beats) * STEP_W;

    // A non power-of-two beat count degrades to an incrementing burst.
    assign mask = (wrap == BURST_WRAP && is_pow2(beats))
                ? span - WIDTH'(1)
                : '1;

endmodule

// File: rtl/bus_addr_seq.sv
// Burst address sequencer: loadable address, strided stepping, beat counter,
// incrementing/wrapping bursts. Ports: Clk, Reset, ld/Din, start/len/wrap,
// adv, oe in; Dout (gated address), busy, last, done out.
module bus_addr_seq
    import bus_addr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LEN_W = 4,
    parameter int STEP  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] Din,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             wrap,
    input  logic             adv,
    input  logic             oe,
    output logic [WIDTH-1:0] Dout,
    output logic             busy,
    output logic             last,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state;
    logic [WIDTH-1:0] addr;
    logic [LEN_W-1:0] rem;
    logic             wrap_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] inc_addr;
    logic [WIDTH-1:0] next_addr;

    bus_wrap_mask #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .STEP  (STEP)
    ) u_mask (
        .len   (len),
        .wrap  (wrap),
        .mask  (mask_d)
    );

    assign inc_addr = addr + STEP_W;

    // Bits above the window hold; bits inside it roll over.
    assign next_addr = (wrap_q == BURST_WRAP)
                     ? ((addr & ~mask_q) | (inc_addr & mask_q))
                     : inc_addr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            addr   <= '0;
            rem    <= '0;
            wrap_q <= BURST_INCR;
            mask_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld) begin
                addr  <= Din;
                state <= IDLE;
                rem   <= '0;
            end else if (start && state == IDLE) begin
                rem    <= len;
                wrap_q <= wrap;
                mask_q <= mask_d;
                state  <= BURST;
            end else if (adv) begin
                if (state == IDLE) begin
                    addr <= inc_addr;
                end else begin
                    addr <= next_addr;
                    if (rem == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        rem <= rem - LEN_W'(1);
                    end
                end
            end
        end
    end

    assign busy = (state == BURST);
    assign last = busy && (rem == '0);
    assign Dout = oe ? addr : '0;

endmodule

// File: tb/tb_bus_addr_seq.sv
// Self-checking bench for bus_addr_seq: vector table plus hand sequences,
// expected outputs queued at drive time and compared after each clock edge.
module tb_bus_addr_seq;

    typedef struct {
        logic        ld;
        logic [63:0] din;
        logic        start;
        logic [3:0]  len;
        logic        wrap;
        logic        adv;
        logic        oe;
        logic [63:0] e_dout;
        logic        e_busy;
        logic        e_last;
        logic        e_done;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic        ld;
    logic [63:0] Din;
    logic        start;
    logic [3:0]  len;
    logic        wrap;
    logic        adv;
    logic        oe;
    logic [63:0] Dout;
    logic        busy;
    logic        last;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl[$];
    vec_t sb[$];

    bus_addr_seq #(
        .WIDTH (64),
        .LEN_W (4),
        .STEP  (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (ld),
        .Din   (Din),
        .start (start),
        .len   (len),
        .wrap  (wrap),
        .adv   (adv),
        .oe    (oe),
        .Dout  (Dout),
        .busy  (busy),
        .last  (last),
        .done  (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(
        input logic ld_i, input logic [63:0] din_i,
        input logic st_i, input logic [3:0] len_i, input logic wr_i,
        input logic adv_i, input logic oe_i,
        input logic [63:0] d_o, input logic b_o,
        input logic l_o, input logic dn_o);
        vec_t v;
        v.ld = ld_i;     v.din = din_i;   v.start = st_i;
        v.len = len_i;   v.wrap = wr_i;   v.adv = adv_i;
        v.oe = oe_i;     v.e_dout = d_o;  v.e_busy = b_o;
        v.e_last = l_o;  v.e_done = dn_o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t e);
        chk({nm, ".Dout"}, Dout, e.e_dout);
        chk({nm, ".busy"}, 64'(busy), 64'(e.e_busy));
        chk({nm, ".last"}, 64'(last), 64'(e.e_last));
        chk({nm, ".done"}, 64'(done), 64'(e.e_done));
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        ld = v.ld;   Din = v.din;   start = v.start;
        len = v.len; wrap = v.wrap; adv = v.adv; oe = v.oe;
        sb.push_back(v);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk_all(nm, e);
        end
    endtask

    initial begin
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Cycle table: ld din start len wrap adv oe | dout busy last done
        tbl.push_back(mk(1, 64'h1000, 0, 0, 0, 0, 0, 64'h0,    0, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1, 64'h1000, 0, 0, 0));
        // incrementing burst, len=3, with an idle gap
        tbl.push_back(mk(1, 64'h100,  0, 0, 0, 0, 1, 64'h100,  0, 0, 0));
        tbl.push_back(mk(0, 0,        1, 3, 0, 0, 1, 64'h100,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h108,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1, 64'h108,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h110,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h118,  1, 1, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h120,  0, 0, 1));
        tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1, 64'h120,  0, 0, 0));
        // wrapping burst, len=3 -> window 0x20
        tbl.push_back(mk(1, 64'h118,  0, 0, 0, 0, 1, 64'h118,  0, 0, 0));
        tbl.push_back(mk(0, 0,        1, 3, 1, 0, 1, 64'h118,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h100,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h108,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h110,  1, 1, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h118,  0, 0, 1));
        // len=2 wrap -> incrementing; start accepted while done is high
        tbl.push_back(mk(0, 0,        1, 2, 1, 0, 1, 64'h118,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h120,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h128,  1, 1, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h130,  0, 0, 1));
        // start while busy ignored; ld beats final adv
        tbl.push_back(mk(1, 64'h200,  0, 0, 0, 0, 1, 64'h200,  0, 0, 0));
        tbl.push_back(mk(0, 0,        1, 1, 0, 0, 1, 64'h200,  1, 0, 0));
        tbl.push_back(mk(0, 0,        1, 5, 0, 1, 1, 64'h208,  1, 1, 0));
        tbl.push_back(mk(1, 64'h300,  0, 0, 0, 1, 1, 64'h300,  0, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1, 64'h300,  0, 0, 0));
        // start+adv in IDLE: adv ignored
        tbl.push_back(mk(0, 0,        1, 0, 0, 1, 1, 64'h300,  1, 1, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h308,  0, 0, 1));
        // overflow in IDLE, then oe gating
        tbl.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 1,
                         64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h0,    0, 0, 0));
        tbl.push_back(mk(1, 64'h55,   0, 0, 0, 0, 0, 64'h0,    0, 0, 0));
        // two-beat wrap, window 0x10
        tbl.push_back(mk(1, 64'h1F8,  0, 0, 0, 0, 1, 64'h1F8,  0, 0, 0));
        tbl.push_back(mk(0, 0,        1, 1, 1, 0, 1, 64'h1F8,  1, 0, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h1F0,  1, 1, 0));
        tbl.push_back(mk(0, 0,        0, 0, 0, 1, 1, 64'h1F8,  0, 0, 1));

        Reset = 1'b1;
        ld = 0; Din = 0; start = 0; len = 0; wrap = 0; adv = 0; oe = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk_all("reset", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("row%0d", i));

        // Reset during beat 2 of a len=7 burst
        step(mk(1, 64'h400, 0, 0, 0, 0, 1, 64'h400, 0, 0, 0), "mr_ld");
        step(mk(0, 0, 1, 7, 0, 0, 1, 64'h400, 1, 0, 0), "mr_start");
        step(mk(0, 0, 0, 0, 0, 1, 1, 64'h408, 1, 0, 0), "mr_adv1");
        adv = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        chk_all("mr_async", z);
        @(negedge Clk);
        Reset = 1'b0;
        step(z, "mr_after");
        step(mk(0, 0, 1, 0, 0, 0, 1, 64'h0, 1, 1, 0), "sb_start");
        step(mk(0, 0, 0, 0, 0, 1, 1, 64'h8, 0, 0, 1), "sb_adv");
        step(z.e_dout == 0 ? mk(0, 0, 0, 0, 0, 0, 1, 64'h8, 0, 0, 0) : z,
             "sb_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
